// File: rtl/multicycle_control_if.sv
// Memory bus between the multicycle controller and instruction/data memory.
// Latency: none, plain wires; the controller registers everything it drives.
// Backpressure: the request holds until the memory answers with mem_ack_i.
interface multicycle_control_if #(
  parameter int XLEN = 32
);
  logic            mem_req_o;
  logic            mem_we_o;
  logic [XLEN-1:0] mem_addr_o;
  logic [XLEN-1:0] mem_wdata_o;
  logic [XLEN-1:0] mem_rdata_i;
  logic            mem_ack_i;

  modport master (
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i, mem_ack_i
  );

  modport slave (
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i, mem_ack_i
  );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle CPU sequencer: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK/HALT stage control.
// Latency: every output is registered; a stage's effect is visible the cycle after it samples.
// Backpressure: stall_i freezes everything unless a memory request is pending (then ack-driven).
module multicycle_control #(
  parameter int XLEN     = 32,
  parameter int CNT_W    = 32,
  parameter int SKIP_MEM = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall_i,
  input  logic [XLEN-1:0]     pc_i,
  output logic                pc_readin_o,
  multicycle_control_if.master mem,
  output logic [XLEN-1:0]     ir_o,
  input  logic [4:0]          itype_i,
  input  logic                load_i,
  input  logic [XLEN-1:0]     alu_result_i,
  input  logic [XLEN-1:0]     rs2_data_i,
  output logic                readin_a_o,
  output logic                readin_b_o,
  output logic                readin_pass_o,
  output logic [XLEN-1:0]     load_data_o,
  output logic                rd_we_o,
  output logic [2:0]          stage_o,
  output logic                halted_o,
  output logic                illegal_o,
  output logic [CNT_W-1:0]    instret_o
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEMORY    = 3'd4,
    S_WRITEBACK = 3'd5,
    S_HALT      = 3'd6
  } stage_e;

  // One-hot instruction-type codes produced by the decoder.
  localparam logic [4:0] IT_RTYPE = 5'b00001;
  localparam logic [4:0] IT_ITYPE = 5'b00010;
  localparam logic [4:0] IT_STYPE = 5'b00100;
  localparam logic [4:0] IT_UTYPE = 5'b01000;
  localparam logic [4:0] IT_HOLD  = 5'b10000;

  stage_e            r_stage, w_stage;
  logic              r_mem_req, w_mem_req;
  logic              r_mem_we, w_mem_we;
  logic [XLEN-1:0]   r_mem_addr, w_mem_addr;
  logic [XLEN-1:0]   r_mem_wdata, w_mem_wdata;
  logic [XLEN-1:0]   r_ir, w_ir;
  logic [XLEN-1:0]   r_load_data, w_load_data;
  logic [2:0]        r_readin, w_readin;
  logic              r_rd_we, w_rd_we;
  logic              r_pc_readin, w_pc_readin;
  logic              r_halted, w_halted;
  logic              r_illegal, w_illegal;
  logic [CNT_W-1:0]  r_instret, w_instret;

  // Next-stage and next-output computation; everything holds unless the stage acts.
  always_comb begin
    w_stage     = r_stage;
    w_mem_req   = r_mem_req;
    w_mem_we    = r_mem_we;
    w_mem_addr  = r_mem_addr;
    w_mem_wdata = r_mem_wdata;
    w_ir        = r_ir;
    w_load_data = r_load_data;
    w_readin    = r_readin;
    w_rd_we     = r_rd_we;
    w_pc_readin = r_pc_readin;
    w_halted    = r_halted;
    w_illegal   = r_illegal;
    w_instret   = r_instret;
    // A pending request cannot be frozen: it completes on the memory's ack.
    if (!stall_i || r_mem_req) begin
      case (r_stage)
        S_IDLE: begin
          w_stage    = S_FETCH;
          w_mem_req  = 1'b1;
          w_mem_we   = 1'b0;
          w_mem_addr = pc_i;
        end
        S_FETCH: begin
          if (r_mem_req && mem.mem_ack_i) begin
            w_ir      = mem.mem_rdata_i;
            w_mem_req = 1'b0;
            w_stage   = S_DECODE;
          end
        end
        S_DECODE: begin
          w_stage = S_EXECUTE;
          case (itype_i)
            IT_RTYPE, IT_ITYPE: w_readin = 3'b110;
            IT_STYPE:           w_readin = 3'b111;
            IT_UTYPE:           w_readin = 3'b001;
            IT_HOLD: begin
              w_readin = 3'b000;
              w_stage  = S_HALT;
              w_halted = 1'b1;
            end
            default: begin
              w_readin  = 3'b000;
              w_stage   = S_HALT;
              w_halted  = 1'b1;
              w_illegal = 1'b1;
            end
          endcase
        end
        S_EXECUTE: begin
          w_readin = 3'b000;
          if ((itype_i == IT_STYPE) || load_i || (SKIP_MEM == 0)) begin
            w_stage = S_MEMORY;
            if (itype_i == IT_STYPE) begin
              w_mem_req   = 1'b1;
              w_mem_we    = 1'b1;
              w_mem_addr  = alu_result_i;
              w_mem_wdata = rs2_data_i;
            end else if (load_i) begin
              w_mem_req  = 1'b1;
              w_mem_we   = 1'b0;
              w_mem_addr = alu_result_i;
            end
          end else begin
            w_stage     = S_WRITEBACK;
            w_pc_readin = 1'b1;
            w_rd_we     = 1'b1;
            w_instret   = r_instret + 1'b1;
          end
        end
        S_MEMORY: begin
          // Without a request this is a single pass-through cycle.
          if (!r_mem_req || mem.mem_ack_i) begin
            if (r_mem_req && !r_mem_we) w_load_data = mem.mem_rdata_i;
            w_mem_req   = 1'b0;
            w_mem_we    = 1'b0;
            w_stage     = S_WRITEBACK;
            w_pc_readin = 1'b1;
            w_rd_we     = !(r_mem_req && r_mem_we);
            w_instret   = r_instret + 1'b1;
          end
        end
        S_WRITEBACK: begin
          w_pc_readin = 1'b0;
          w_rd_we     = 1'b0;
          w_stage     = S_FETCH;
          w_mem_req   = 1'b1;
          w_mem_we    = 1'b0;
          w_mem_addr  = pc_i;
        end
        default: ;
      endcase
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_stage     <= S_IDLE;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_ir        <= '0;
      r_load_data <= '0;
      r_readin    <= 3'b000;
      r_rd_we     <= 1'b0;
      r_pc_readin <= 1'b0;
      r_halted    <= 1'b0;
      r_illegal   <= 1'b0;
      r_instret   <= '0;
    end else begin
      r_stage     <= w_stage;
      r_mem_req   <= w_mem_req;
      r_mem_we    <= w_mem_we;
      r_mem_addr  <= w_mem_addr;
      r_mem_wdata <= w_mem_wdata;
      r_ir        <= w_ir;
      r_load_data <= w_load_data;
      r_readin    <= w_readin;
      r_rd_we     <= w_rd_we;
      r_pc_readin <= w_pc_readin;
      r_halted    <= w_halted;
      r_illegal   <= w_illegal;
      r_instret   <= w_instret;
    end
  end

  assign mem.mem_req_o   = r_mem_req;
  assign mem.mem_we_o    = r_mem_we;
  assign mem.mem_addr_o  = r_mem_addr;
  assign mem.mem_wdata_o = r_mem_wdata;
  assign ir_o            = r_ir;
  assign load_data_o     = r_load_data;
  assign readin_a_o      = r_readin[2];
  assign readin_b_o      = r_readin[1];
  assign readin_pass_o   = r_readin[0];
  assign rd_we_o         = r_rd_we;
  assign pc_readin_o     = r_pc_readin;
  assign stage_o         = r_stage;
  assign halted_o        = r_halted;
  assign illegal_o       = r_illegal;
  assign instret_o       = r_instret;

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter XLEN, default 32: width of the address, data, instruction and PC paths.
REQ-002 Parameter CNT_W, default 32: width of the retired-instruction counter.
REQ-003 Parameter SKIP_MEM, default 1: when 1, non-memory instructions bypass the MEMORY stage; when 0, every instruction passes through MEMORY.
REQ-004 clk  in  1  single clock; all state changes on the rising edge.
REQ-005 reset  in  1  synchronous, active-low reset.
REQ-006 stall_i  in  1  hold the current stage.
REQ-007 pc_i  in  XLEN  current PC.
REQ-008 pc_readin_o  out  1  one-cycle pulse that advances the PC.
REQ-009 mem_req_o  out  1  memory request valid.
REQ-010 mem_we_o  out  1  write enable, qualified by mem_req_o.
REQ-011 mem_addr_o  out  XLEN  memory address.
REQ-012 mem_wdata_o  out  XLEN  store data.
REQ-013 mem_rdata_i  in  XLEN  read data, valid with mem_ack_i.
REQ-014 mem_ack_i  in  1  request complete.
REQ-015 ir_o  out  XLEN  instruction register.
REQ-016 itype_i  in  5  decoded type, using the itype.v codes RTYPE/ITYPE/STYPE/UTYPE/HOLD.
REQ-017 load_i  in  1  decoded instruction is a load.
REQ-018 alu_result_i  in  XLEN  effective address for loads and stores.
REQ-019 rs2_data_i  in  XLEN  store source data.
REQ-020 readin_a_o, readin_b_o, readin_pass_o  out  1 each  ALU operand latch enables.
REQ-021 load_data_o  out  XLEN  captured load data.
REQ-022 rd_we_o  out  1  register-file write pulse.
REQ-023 stage_o  out  3  stage code: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEMORY=4, WRITEBACK=5, HALT=6.
REQ-024 halted_o, illegal_o  out  1 each  halted flag; halt caused by an unknown itype.
REQ-025 instret_o  out  CNT_W  count of retired instructions.

Function
REQ-026 All outputs SHALL be registered, and a stage SHALL act on inputs sampled in that stage.
REQ-027 IDLE SHALL go to FETCH in the cycle after reset deasserts.
REQ-028 FETCH: mem_req_o=1, mem_we_o=0, mem_addr_o=pc_i; hold until mem_ack_i=1 is sampled; then ir_o<=mem_rdata_i and go to DECODE.
REQ-029 An ack in the first cycle of a request SHALL be accepted; mem_req_o SHALL drop in the cycle after the ack; mem_ack_i SHALL be ignored while mem_req_o=0.
REQ-030 DECODE SHALL last 1 cycle and set {readin_a_o,readin_b_o,readin_pass_o}: RTYPE/ITYPE 110, STYPE 111, UTYPE 001, HOLD 000.
REQ-031 DECODE with HOLD SHALL go to HALT; any other uncoded itype SHALL go to HALT and set illegal_o=1.
REQ-032 EXECUTE SHALL last 1 cycle and clear all readin_* outputs.
REQ-033 EXECUTE SHALL go to MEMORY if STYPE, if load_i=1, or if SKIP_MEM=0; otherwise it SHALL go to WRITEBACK.
REQ-034 MEMORY store: mem_req_o=1, mem_we_o=1, mem_addr_o=alu_result_i, mem_wdata_o=rs2_data_i; wait for ack.
REQ-035 MEMORY load: mem_req_o=1, mem_we_o=0, mem_addr_o=alu_result_i; on ack, load_data_o<=mem_rdata_i.
REQ-036 MEMORY for a non-memory instruction SHALL last 1 cycle with no request.
REQ-037 WRITEBACK SHALL last 1 cycle: pc_readin_o=1; rd_we_o=1 unless STYPE; instret_o increments; then go to FETCH.
REQ-038 instret_o SHALL wrap from 2^CNT_W-1 to 0.
REQ-039 pc_readin_o and rd_we_o SHALL be 0 outside WRITEBACK.
REQ-040 stall_i=1 SHALL freeze state and all outputs, except while mem_req_o=1, where it is ignored until the ack.
REQ-041 HALT SHALL hold halted_o=1 and all other control outputs at 0; only reset exits HALT.

Reset
REQ-042 reset=0 at a clock edge SHALL take priority over all activity, including an outstanding request or a simultaneous ack.
REQ-043 On that edge the block SHALL set stage_o=0 and every other output to 0 (including ir_o, load_data_o and instret_o).

Verification
REQ-044 RTYPE fetch with ack on the first request cycle -> stage sequence 1,2,3,5,1; readin 110 in DECODE; rd_we_o and pc_readin_o pulse once; instret_o=1.
REQ-045 STYPE, alu_result_i=0x100, rs2_data_i=0xDEADBEEF, ack delayed 3 cycles -> MEMORY holds 4 cycles with we=1, addr 0x100, wdata 0xDEADBEEF; rd_we_o stays 0.
REQ-046 Load, mem_rdata_i=0x12345678 on ack; SKIP_MEM=0 with ITYPE -> load_data_o=0x12345678; the ITYPE instruction spends exactly 1 cycle in MEMORY.
REQ-047 HOLD opcode -> HALT, halted_o=1, illegal_o=0; an unknown itype -> illegal_o=1; the block stays halted for 20 cycles, then reset=0 for 1 cycle -> IDLE.
REQ-048 reset=0 mid-FETCH with ack in the same cycle -> ir_o=0 and mem_req_o=0 next cycle; stall_i=1 during DECODE -> stage frozen for the stall duration.
REQ-049 CNT_W=4, 17 retired instructions -> instret_o=1.
